fcw_sweep_ctrl: RTL and testbench
=================================

Name: fcw_sweep_ctrl

Overview:
Sequencer that drives the frequency control word of the FCW NCO (sine/cosine DDS, 250 MHz clk) to produce stepped frequency sweeps, sawtooth repeats, triangle sweeps or a fixed hold. It latches a sweep program on a start pulse, holds each FCW value for a programmed dwell, then steps it by a signed increment. fcw_out connects directly to the NCO fcw_input.

Parameters:
FCW_W, 32, FCW / accumulator width; all FCW arithmetic is modulo 2^FCW_W.
CNT_W, 24, dwell counter width in clk cycles.
STEP_W, 16, step-count and step-index width.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle request; sampled only in IDLE.
abort  in  1  stop the sweep; held FCW is kept.
mode  in  2  0 single up-sweep, 1 sawtooth repeat, 2 triangle continuous, 3 hold start_fcw.
start_fcw  in  FCW_W  first FCW value.
step_fcw  in  FCW_W  two's-complement increment per step.
num_steps  in  STEP_W  steps per leg, N.
dwell_cycles  in  CNT_W  cycles per FCW value; 0 is treated as 1.
fcw_out  out  FCW_W  FCW to the NCO.
fcw_valid  out  1  one-cycle pulse on every fcw_out load.
busy  out  1  high from the cycle after start is accepted until done or abort.
done  out  1  one-cycle pulse at the end of a mode-0 sweep.
step_idx  out  STEP_W  current step index within the leg.

Behaviour:
- Reset (async, rst_n=0): fcw_out=0, fcw_valid=0, busy=0, done=0, step_idx=0, dir=up, dwell_cnt=0, state=IDLE. Reset mid-sweep aborts immediately with no done pulse.
- States: IDLE, DWELL. Let D = max(dwell_cycles, 1).
- IDLE + start (abort=0) at cycle t: latch mode, start_fcw, step_fcw, num_steps and D into shadow registers. At t+1: fcw_out=start_fcw, fcw_valid=1, busy=1, step_idx=0, dir=up, dwell_cnt=D-1, state=DWELL.
- Config inputs are ignored after latching.
- DWELL, dwell_cnt != 0: decrement. Every fcw_out value is held exactly D cycles.
- DWELL, dwell_cnt == 0, step_idx != N (modes 0-2): fcw_out += step_fcw when dir=up, -= step_fcw when dir=down. Also step_idx++, dwell_cnt=D-1, fcw_valid pulse.
- End of leg (dwell_cnt == 0, step_idx == N, N != 0):
  - mode 0: busy=0, done=1 for one cycle, state=IDLE, fcw_out holds start+N*step.
  - mode 1: fcw_out=start_fcw, step_idx=0, fcw_valid pulse, reload dwell.
  - mode 2: toggle dir, apply one step in the new direction, step_idx=1, fcw_valid pulse, reload dwell. Period is 2N values.
- N == 0: mode 0 dwells start_fcw for D cycles, then done. Modes 1/2 behave like mode 3.
- Mode 3: hold start_fcw indefinitely; no further fcw_valid pulses; exits only on abort or reset.
- abort in DWELL: next cycle state=IDLE, busy=0, no done, fcw_out and step_idx held. Abort beats a same-cycle dwell expiry.
- start while busy: ignored. start+abort in the same IDLE cycle: abort wins, start is ignored.
- done and fcw_valid are never asserted in the same cycle.
- FCW add/sub wraps modulo 2^FCW_W; no saturation, no overflow flag.

Decomposition:
- Package fcw_ctrl_pkg holds:
  - state enum (IDLE, DWELL);
  - mode encodings MODE_SINGLE=0, MODE_SAW=1, MODE_TRI=2, MODE_HOLD=3;
  - default widths.
- One natural sub-module, fcw_dwell_timer: loadable down-counter with a load value, a zero flag and clear-on-abort.

Test Plan:
1. mode0, start_fcw=17179, step=17180, N=2, dwell=4 -> fcw_out 17179/34359/51539, each for 4 cycles; 3 fcw_valid pulses; done pulse at t+13; busy low at t+13; fcw_out stays 51539.
2. mode2, start=1000, step=100, N=3, dwell=2 -> sequence 1000,1100,1200,1300,1200,1100,1000,1100..., each value 2 cycles, no done; abort mid-sweep -> busy=0 next cycle, fcw_out frozen, no done.
3. Wrap: mode0, start=32'hFFFF_FFF0, step=32'h0000_0020, N=1, dwell=1 -> fcw_out 32'hFFFF_FFF0 then 32'h0000_0010; also step=-8590 (two's complement) from 8590 -> 0.
4. dwell_cycles=0, N=2, mode1 -> each value held exactly 1 cycle, fcw_valid high every cycle, sawtooth reload to start_fcw. start pulsed while busy with different config -> ignored, sequence unchanged.
5. Simultaneous events: start+abort in the same IDLE cycle -> stays IDLE, fcw_out unchanged; abort on the dwell-expiry cycle -> no step applied.
6. rst_n low mid-sweep (asynchronous, between clock edges) -> all outputs 0 immediately. After release, a new start runs cleanly from start_fcw. mode3 -> start_fcw held 1000 cycles with a single fcw_valid pulse.

Source files
------------

// File: rtl/fcw_sweep_ctrl_pkg.sv
// Purpose: shared types, mode encodings and default widths for the FCW sweep sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a; the NCO consumes fcw_out every cycle and never stalls.
package fcw_ctrl_pkg;

  localparam int FCW_W_DEF  = 32;
  localparam int CNT_W_DEF  = 24;
  localparam int STEP_W_DEF = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } state_t;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;
  localparam logic [1:0] MODE_HOLD   = 2'd3;

endpackage

// File: rtl/fcw_sweep_ctrl_if.sv
// Purpose: command/config and FCW output bundle between a sweep master and the sequencer.
// Latency: n/a (wires only).
// Backpressure: none; start is a one-cycle request, outputs are pulses/levels.
interface fcw_sweep_if
  import fcw_ctrl_pkg::*;
#(
  parameter int FCW_W  = FCW_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int STEP_W = STEP_W_DEF
);
  logic              start;
  logic              abort;
  logic [1:0]        mode;
  logic [FCW_W-1:0]  start_fcw;
  logic [FCW_W-1:0]  step_fcw;
  logic [STEP_W-1:0] num_steps;
  logic [CNT_W-1:0]  dwell_cycles;
  logic [FCW_W-1:0]  fcw_out;
  logic              fcw_valid;
  logic              busy;
  logic              done;
  logic [STEP_W-1:0] step_idx;

  modport master (
    output start, abort, mode, start_fcw, step_fcw, num_steps, dwell_cycles,
    input  fcw_out, fcw_valid, busy, done, step_idx
  );

  modport slave (
    input  start, abort, mode, start_fcw, step_fcw, num_steps, dwell_cycles,
    output fcw_out, fcw_valid, busy, done, step_idx
  );
endinterface

// File: rtl/fcw_sweep_ctrl_dwell_timer.sv
// Purpose: loadable dwell down-counter with zero flag and clear.
// Latency: load/clear/decrement take effect on the next clk edge; zero is combinational from the count.
// Backpressure: none; dec is ignored once the count reaches zero.
module fcw_dwell_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             clear,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  // Clear wins so an abort always leaves the timer parked at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/fcw_sweep_ctrl.sv
// Purpose: sequences the NCO frequency control word through single, sawtooth, triangle or hold sweeps.
// Latency: first FCW one cycle after an accepted start; each FCW value held max(dwell_cycles,1) cycles.
// Backpressure: none; start is ignored while busy, abort wins over start and over a dwell expiry.
module fcw_sweep_ctrl
  import fcw_ctrl_pkg::*;
#(
  parameter int FCW_W  = FCW_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  fcw_sweep_if.slave  bus
);

  state_t            state_q, state_d;
  logic [FCW_W-1:0]  fcw_q, fcw_d;
  logic              vld_q, vld_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [STEP_W-1:0] idx_q, idx_d;
  logic              dir_q, dir_d;   // 0 = up, 1 = down

  // Config shadow, frozen for the life of a sweep.
  logic [1:0]        mode_s;
  logic [FCW_W-1:0]  start_s;
  logic [FCW_W-1:0]  step_s;
  logic [STEP_W-1:0] n_s;
  logic [CNT_W-1:0]  dm1_s;          // D-1 reload value

  logic              latch;
  logic              tmr_load, tmr_dec, tmr_clr, tmr_zero;
  logic [CNT_W-1:0]  tmr_load_val;
  logic [CNT_W-1:0]  dwell_in_m1;
  logic              hold_mode;

  // A zero dwell behaves as a one-cycle dwell, so the reload is floored at 0.
  assign dwell_in_m1 = (bus.dwell_cycles == '0) ? '0 : (bus.dwell_cycles - CNT_W'(1));

  // Saw/triangle with no steps degenerate to a plain hold.
  assign hold_mode = (mode_s == MODE_HOLD) || ((mode_s != MODE_SINGLE) && (n_s == '0));

  fcw_dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .clear    (tmr_clr),
    .zero     (tmr_zero)
  );

  // Next-state and next-output decode; every target gets its hold value first.
  always_comb begin
    state_d      = state_q;
    fcw_d        = fcw_q;
    vld_d        = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    idx_d        = idx_q;
    dir_d        = dir_q;
    latch        = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = dm1_s;
    tmr_dec      = 1'b0;
    tmr_clr      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          latch        = 1'b1;
          state_d      = DWELL;
          fcw_d        = bus.start_fcw;
          vld_d        = 1'b1;
          busy_d       = 1'b1;
          idx_d        = '0;
          dir_d        = 1'b0;
          tmr_load     = 1'b1;
          tmr_load_val = dwell_in_m1;
        end
      end
      DWELL: begin
        if (bus.abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          tmr_clr = 1'b1;
        end else if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else if (hold_mode) begin
          // Hold: start_fcw stays put until abort or reset.
        end else if (idx_q != n_s) begin
          fcw_d    = dir_q ? (fcw_q - step_s) : (fcw_q + step_s);
          idx_d    = idx_q + STEP_W'(1);
          vld_d    = 1'b1;
          tmr_load = 1'b1;
        end else begin
          unique case (mode_s)
            MODE_SAW: begin
              fcw_d    = start_s;
              idx_d    = '0;
              vld_d    = 1'b1;
              tmr_load = 1'b1;
            end
            MODE_TRI: begin
              dir_d    = ~dir_q;
              fcw_d    = dir_q ? (fcw_q + step_s) : (fcw_q - step_s);
              idx_d    = STEP_W'(1);
              vld_d    = 1'b1;
              tmr_load = 1'b1;
            end
            default: begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fcw_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcw_q   <= fcw_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
    end
  end

  // Capture the sweep program on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_s  <= MODE_SINGLE;
      start_s <= '0;
      step_s  <= '0;
      n_s     <= '0;
      dm1_s   <= '0;
    end else if (latch) begin
      mode_s  <= bus.mode;
      start_s <= bus.start_fcw;
      step_s  <= bus.step_fcw;
      n_s     <= bus.num_steps;
      dm1_s   <= dwell_in_m1;
    end
  end

  assign bus.fcw_out   = fcw_q;
  assign bus.fcw_valid = vld_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.step_idx  = idx_q;

endmodule

// File: tb/tb_fcw_sweep_ctrl.sv
// Purpose: directed scoreboard bench for the FCW sweep sequencer.
// Latency: expects first FCW one cycle after start and each value held max(dwell,1) cycles.
// Backpressure: none modelled; every fcw_valid pulse must match the next queued expectation.
module tb_fcw_sweep_ctrl;
  import fcw_ctrl_pkg::*;

  typedef struct {
    logic [31:0] fcw;
    logic [15:0] idx;
    int          gap;   // cycles since previous pulse; 0 = not checked
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];
  int   checks, errors;
  int   cyc, last_vld, done_cnt;
  logic [31:0] last_fcw;

  fcw_sweep_if #(.FCW_W(32), .CNT_W(24), .STEP_W(16)) bus ();

  fcw_sweep_ctrl #(.FCW_W(32), .CNT_W(24), .STEP_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock; sample at the falling edge and score any FCW load.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (bus.done) done_cnt++;
    if (bus.fcw_valid || bus.done)
      check("vld_done_excl", 64'(bus.fcw_valid & bus.done), 64'd0);
    if (bus.fcw_valid) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_vld: got fcw=%0h with empty scoreboard", bus.fcw_out);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_fcw", 64'(bus.fcw_out), 64'(e.fcw));
        check("sb_idx", 64'(bus.step_idx), 64'(e.idx));
        if (e.gap != 0) check("sb_gap", 64'(cyc - last_vld), 64'(e.gap));
        last_fcw = e.fcw;
      end
      last_vld = cyc;
    end
  endtask

  // Reference sequence generator from the sweep description.
  task automatic push_seq(input logic [1:0] m, input logic [31:0] sf, input logic [31:0] st,
                          input int n, input int d, input int count);
    logic [31:0] f;
    int          idx;
    bit          down;
    f = sf; idx = 0; down = 1'b0;
    for (int k = 0; k < count; k++) begin
      sb.push_back('{fcw: f, idx: 16'(idx), gap: (k == 0) ? 0 : d});
      if (m == MODE_HOLD) break;
      if (idx != n) begin
        f = down ? f - st : f + st;
        idx++;
      end else if (m == MODE_SAW) begin
        f = sf;
        idx = 0;
      end else if (m == MODE_TRI) begin
        down = !down;
        f = down ? f - st : f + st;
        idx = 1;
      end
    end
  endtask

  task automatic start_sweep(input logic [1:0] m, input logic [31:0] sf, input logic [31:0] st,
                             input logic [15:0] n, input logic [23:0] dw);
    bus.mode = m; bus.start_fcw = sf; bus.step_fcw = st;
    bus.num_steps = n; bus.dwell_cycles = dw;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.done) begin
        at = cyc;
        break;
      end
    end
    check("done_timeout", 64'(at >= 0), 64'd1);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic abort_sweep();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int t1, at, dref;
    checks = 0; errors = 0; cyc = 0; last_vld = 0; done_cnt = 0; last_fcw = '0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 2'd0;
    bus.start_fcw = '0; bus.step_fcw = '0; bus.num_steps = '0; bus.dwell_cycles = '0;

    // Reset state
    #2;
    check("rst_fcw", 64'(bus.fcw_out), 64'd0);
    check("rst_vld", 64'(bus.fcw_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_idx", 64'(bus.step_idx), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: single up-sweep, done 13 cycles after start
    push_seq(MODE_SINGLE, 32'd17179, 32'd17180, 2, 4, 3);
    start_sweep(MODE_SINGLE, 32'd17179, 32'd17180, 16'd2, 24'd4);
    t1 = cyc;
    check("t1_busy", 64'(bus.busy), 64'd1);
    wait_done(40, at);
    check("t1_done_lat", 64'(at - t1), 64'd12);
    check("t1_busy_off", 64'(bus.busy), 64'd0);
    check("t1_fcw_end", 64'(bus.fcw_out), 64'd51539);
    check("t1_sb_empty", 64'(sb.size()), 64'd0);
    tick();
    check("t1_done_pulse", 64'(bus.done), 64'd0);
    check("t1_fcw_hold", 64'(bus.fcw_out), 64'd51539);

    // 2: triangle, then abort mid-sweep
    push_seq(MODE_TRI, 32'd1000, 32'd100, 3, 2, 9);
    check("t2_tri_turn", 64'(sb[4].fcw), 64'd1200);
    check("t2_tri_wrap", 64'(sb[7].fcw), 64'd1100);
    start_sweep(MODE_TRI, 32'd1000, 32'd100, 16'd3, 24'd2);
    drain(40);
    dref = done_cnt;
    abort_sweep();
    check("t2_fcw_frozen", 64'(bus.fcw_out), 64'd1200);
    check("t2_idx_frozen", 64'(bus.step_idx), 64'd2);
    for (int i = 0; i < 10; i++) tick();
    check("t2_no_done", 64'(done_cnt), 64'(dref));

    // 3: modular wrap in both directions
    push_seq(MODE_SINGLE, 32'hFFFF_FFF0, 32'h0000_0020, 1, 1, 2);
    start_sweep(MODE_SINGLE, 32'hFFFF_FFF0, 32'h0000_0020, 16'd1, 24'd1);
    wait_done(20, at);
    check("t3_wrap_up", 64'(bus.fcw_out), 64'h0000_0010);
    push_seq(MODE_SINGLE, 32'd8590, 32'(-8590), 1, 1, 2);
    start_sweep(MODE_SINGLE, 32'd8590, 32'(-8590), 16'd1, 24'd1);
    wait_done(20, at);
    check("t3_neg_step", 64'(bus.fcw_out), 64'd0);

    // 4: zero dwell sawtooth; start while busy is ignored
    push_seq(MODE_SAW, 32'd500, 32'd7, 2, 1, 9);
    start_sweep(MODE_SAW, 32'd500, 32'd7, 16'd2, 24'd0);
    tick();
    tick();
    bus.mode = MODE_SINGLE; bus.start_fcw = 32'd9999; bus.step_fcw = 32'd1;
    bus.num_steps = 16'd9; bus.dwell_cycles = 24'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    drain(40);
    abort_sweep();
    check("t4_last_fcw", 64'(bus.fcw_out), 64'd514);

    // 5a: start and abort together in IDLE
    dref = done_cnt;
    bus.mode = MODE_SINGLE; bus.start_fcw = 32'd4242; bus.num_steps = 16'd1; bus.dwell_cycles = 24'd1;
    bus.start = 1'b1; bus.abort = 1'b1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    check("t5_idle_busy", 64'(bus.busy), 64'd0);
    check("t5_idle_fcw", 64'(bus.fcw_out), 64'(last_fcw));
    tick();
    check("t5_idle_busy2", 64'(bus.busy), 64'd0);

    // 5b: abort on the dwell-expiry cycle suppresses the step
    push_seq(MODE_SINGLE, 32'd100, 32'd10, 3, 3, 1);
    start_sweep(MODE_SINGLE, 32'd100, 32'd10, 16'd3, 24'd3);
    tick();
    tick();
    abort_sweep();
    check("t5_exp_fcw", 64'(bus.fcw_out), 64'd100);
    check("t5_exp_idx", 64'(bus.step_idx), 64'd0);
    for (int i = 0; i < 6; i++) tick();
    check("t5_no_done", 64'(done_cnt), 64'(dref));

    // 6a: asynchronous reset mid-sweep
    push_seq(MODE_SINGLE, 32'd4000, 32'd1, 5, 3, 6);
    start_sweep(MODE_SINGLE, 32'd4000, 32'd1, 16'd5, 24'd3);
    for (int i = 0; i < 4; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_fcw", 64'(bus.fcw_out), 64'd0);
    check("t6_rst_vld", 64'(bus.fcw_valid), 64'd0);
    check("t6_rst_busy", 64'(bus.busy), 64'd0);
    check("t6_rst_done", 64'(bus.done), 64'd0);
    check("t6_rst_idx", 64'(bus.step_idx), 64'd0);
    sb.delete();
    dref = done_cnt;
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_no_done", 64'(done_cnt), 64'(dref));
    push_seq(MODE_SINGLE, 32'd77, 32'd3, 1, 2, 2);
    start_sweep(MODE_SINGLE, 32'd77, 32'd3, 16'd1, 24'd2);
    wait_done(20, at);
    check("t6_restart_fcw", 64'(bus.fcw_out), 64'd80);

    // 6b: hold mode keeps start_fcw with a single load pulse
    push_seq(MODE_HOLD, 32'd12345, 32'd5, 4, 2, 5);
    start_sweep(MODE_HOLD, 32'd12345, 32'd5, 16'd4, 24'd2);
    for (int i = 0; i < 1000; i++) tick();
    check("t6_hold_fcw", 64'(bus.fcw_out), 64'd12345);
    check("t6_hold_busy", 64'(bus.busy), 64'd1);
    check("t6_hold_idx", 64'(bus.step_idx), 64'd0);
    abort_sweep();
    check("t6_hold_after", 64'(bus.fcw_out), 64'd12345);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
